// File: rtl/reg_file_pkg.sv
// Shared constants for the register file: default widths, register count and
// the index of the hardwired-zero register.
package reg_file_pkg;

  localparam int unsigned DATA_W_DEF   = 32'd32;
  localparam int unsigned ADDR_W_DEF   = 32'd5;
  localparam int unsigned NUM_REGS_DEF = 32'd1 << ADDR_W_DEF;
  localparam int unsigned ZERO_REG_IDX = 32'd0;

endpackage : reg_file_pkg

// File: rtl/reg_file_read_port.sv
// One combinational read port: decode, register-0 masking and, when
// REGFILE_BYPASS_EN is defined, write-to-read forwarding.
module reg_file_read_port
  import reg_file_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic [DATA_W-1:0] regArray [2**ADDR_W],
  input  logic [ADDR_W-1:0] readAddress,
`ifdef REGFILE_BYPASS_EN
  input  logic              bypassValid,
  input  logic [ADDR_W-1:0] writeAddress,
  input  logic [DATA_W-1:0] writeData,
`endif
  output logic [DATA_W-1:0] readData
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG_IDX);

  // Select the addressed register, forcing register 0 to read as zero.
  always_comb begin
    readData = '0;
    if (readAddress == ZERO_ADDR) begin
      readData = '0;
    end
`ifdef REGFILE_BYPASS_EN
    else if (bypassValid && (writeAddress == readAddress)) begin
      readData = writeData;
    end
`endif
    else begin
      readData = regArray[readAddress];
    end
  end

endmodule : reg_file_read_port

// File: rtl/reg_file.sv
// 2**ADDR_W x DATA_W register file, one write port and two combinational read
// ports; register 0 is hardwired zero. Optional macro: REGFILE_BYPASS_EN.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              writeEnable,
  input  logic [ADDR_W-1:0] readAddress1,
  input  logic [ADDR_W-1:0] readAddress2,
  input  logic [ADDR_W-1:0] writeAddress,
  input  logic [DATA_W-1:0] writeData,
  output logic [DATA_W-1:0] read1,
  output logic [DATA_W-1:0] read2
);

  localparam int unsigned       NUM_REGS  = 32'd1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG_IDX);

  logic [DATA_W-1:0] regArray_r [NUM_REGS];
  logic              writeValid_s;

  assign writeValid_s = writeEnable && (writeAddress != ZERO_ADDR);

  // Register storage: cleared asynchronously, written on the rising edge.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regArray_r[i] <= '0;
      end
    end else if (writeValid_s) begin
      regArray_r[writeAddress] <= writeData;
    end
  end

`ifdef REGFILE_BYPASS_EN
  // Forwarding is suppressed in reset so reads stay zero while RST_N is low.
  logic bypassValid_s;
  assign bypassValid_s = writeEnable && RST_N;
`endif

  reg_file_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_readPort1 (
    .regArray     (regArray_r),
    .readAddress  (readAddress1),
`ifdef REGFILE_BYPASS_EN
    .bypassValid  (bypassValid_s),
    .writeAddress (writeAddress),
    .writeData    (writeData),
`endif
    .readData     (read1)
  );

  reg_file_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_readPort2 (
    .regArray     (regArray_r),
    .readAddress  (readAddress2),
`ifdef REGFILE_BYPASS_EN
    .bypassValid  (bypassValid_s),
    .writeAddress (writeAddress),
    .writeData    (writeData),
`endif
    .readData     (read2)
  );

endmodule : reg_file

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file; expectations follow the build's
// REGFILE_BYPASS_EN setting.
module tb_reg_file;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        writeEnable;
  logic [4:0]  readAddress1;
  logic [4:0]  readAddress2;
  logic [4:0]  writeAddress;
  logic [31:0] writeData;
  logic [31:0] read1;
  logic [31:0] read2;

  int compareCount  = 0;
  int mismatchCount = 0;

  reg_file #(.DATA_W(32), .ADDR_W(5)) dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .writeEnable  (writeEnable),
    .readAddress1 (readAddress1),
    .readAddress2 (readAddress2),
    .writeAddress (writeAddress),
    .writeData    (writeData),
    .read1        (read1),
    .read2        (read2)
  );

  always #50 CLK = ~CLK;

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compareCount++;
    if (obs !== exp) begin
      mismatchCount++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic doWrite(input logic [4:0] addr, input logic [31:0] data);
    @(negedge CLK);
    writeEnable  = 1'b1;
    writeAddress = addr;
    writeData    = data;
    @(negedge CLK);
    writeEnable  = 1'b0;
  endtask

  task automatic check1(input string tag, input logic [4:0] addr, input logic [31:0] exp);
    readAddress1 = addr;
    #1;
    checkValue(tag, read1, exp);
  endtask

  task automatic check2(input string tag, input logic [4:0] addr, input logic [31:0] exp);
    readAddress2 = addr;
    #1;
    checkValue(tag, read2, exp);
  endtask

  logic [31:0] sameCycleExp;

  initial begin
`ifdef REGFILE_BYPASS_EN
    sameCycleExp = 32'h0000_0009;
`else
    sameCycleExp = 32'h0000_0005;
`endif
    RST_N        = 1'b0;
    writeEnable  = 1'b1;
    writeAddress = 5'd4;
    writeData    = 32'hAAAA_5555;
    readAddress1 = 5'd4;
    readAddress2 = 5'd4;

    // Reset held across edges with a write pending: nothing may land.
    repeat (2) @(negedge CLK);
    #1;
    checkValue("rst_read1", read1, 32'h0000_0000);
    checkValue("rst_read2", read2, 32'h0000_0000);
    writeEnable = 1'b0;
    RST_N       = 1'b1;

    // First edge after reset release accepts the write.
    doWrite(5'd4, 32'h0001_0000);
    check1("wr_addr4", 5'd4, 32'h0001_0000);

    // Write disabled.
    @(negedge CLK);
    writeEnable  = 1'b0;
    writeAddress = 5'd5;
    writeData    = 32'h0001_0000;
    @(negedge CLK);
    check2("wr_disabled_addr5", 5'd5, 32'h0000_0000);

    // Register zero discards writes.
    doWrite(5'd0, 32'hDEAD_BEEF);
    check1("zero_reg_r1", 5'd0, 32'h0000_0000);
    check2("zero_reg_r2", 5'd0, 32'h0000_0000);

    // Dual read.
    doWrite(5'd1, 32'h0000_0011);
    doWrite(5'd2, 32'h0000_0022);
    doWrite(5'd3, 32'h0000_0033);
    readAddress1 = 5'd2;
    readAddress2 = 5'd2;
    #1;
    checkValue("dual_same_r1", read1, 32'h0000_0022);
    checkValue("dual_same_r2", read2, 32'h0000_0022);
    check2("dual_r2_addr3", 5'd3, 32'h0000_0033);
    check1("dual_r1_addr1", 5'd1, 32'h0000_0011);
    check1("keep_addr4", 5'd4, 32'h0001_0000);

    // Same-cycle read and write of register 7.
    doWrite(5'd7, 32'h0000_0005);
    @(negedge CLK);
    readAddress1 = 5'd7;
    readAddress2 = 5'd3;
    writeEnable  = 1'b1;
    writeAddress = 5'd7;
    writeData    = 32'h0000_0009;
    #1;
    checkValue("rw7_before_edge", read1, sameCycleExp);
    checkValue("rw7_other_port", read2, 32'h0000_0033);
    @(negedge CLK);
    writeEnable = 1'b0;
    #1;
    checkValue("rw7_after_edge", read1, 32'h0000_0009);

    // Same-cycle write to register 0 must never forward.
    @(negedge CLK);
    readAddress1 = 5'd0;
    writeEnable  = 1'b1;
    writeAddress = 5'd0;
    writeData    = 32'h1234_5678;
    #1;
    checkValue("rw0_no_forward", read1, 32'h0000_0000);
    @(negedge CLK);
    writeEnable = 1'b0;

    doWrite(5'd31, 32'hCAFE_F00D);
    check2("wr_addr31", 5'd31, 32'hCAFE_F00D);

    // Mid-run asynchronous reset, all addresses read between clock edges.
    @(negedge CLK);
    #1;
    RST_N        = 1'b0;
    writeEnable  = 1'b1;
    writeAddress = 5'd9;
    writeData    = 32'h0000_FFFF;
    for (int i = 0; i < 32; i++) begin
      readAddress1 = 5'(i);
      readAddress2 = 5'(31 - i);
      #1;
      checkValue($sformatf("async_rst_r1_a%0d", i), read1, 32'h0000_0000);
      checkValue($sformatf("async_rst_r2_a%0d", 31 - i), read2, 32'h0000_0000);
    end
    @(negedge CLK);
    check1("rst_ignores_write", 5'd9, 32'h0000_0000);
    writeEnable = 1'b0;
    RST_N       = 1'b1;

    doWrite(5'd9, 32'h0000_1234);
    check1("post_rst_write", 5'd9, 32'h0000_1234);
    check2("post_rst_addr4", 5'd4, 32'h0000_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule : tb_reg_file
